sram_chunk_loader: RTL and testbench

Write-side sequencer for the IFM and filter chunk SRAMs of the compute-cluster memory wrapper. It accepts a valid/ready beat stream of sparsemap and nonzero-data words from the DMA/host side, and drives one SRAM write port: `wr_valid`, `wr_sparsemap`, `wr_nonzero_data`, beat index `wr_dat_count` and chunk index `wr_chunk_count`. One instance serves the IFM SRAM and one serves the filter SRAM; it is the transmitter for the SRAM write interface.

---
 rtl/sram_chunk_loader_pkg.sv | 19 +
 rtl/sram_chunk_loader_if.sv | 36 +++
 rtl/sram_chunk_loader_popcount.sv | 17 +
 rtl/sram_chunk_loader.sv | 120 ++++++++++++
 tb/tb_sram_chunk_loader.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_chunk_loader_pkg.sv
// Shared types and width helpers for the SRAM chunk loader.
package loader_pkg;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} loader_state_e;

  localparam int LD_BUS_SIZE    = 32;
  localparam int LD_DAT_CYC_NUM = 4;
  localparam int LD_CHUNK_NUM   = 8;

  // Counter width for an index range of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_W  = cnt_w(LD_DAT_CYC_NUM);
  localparam int CHUNK_W = cnt_w(LD_CHUNK_NUM);
  localparam int NNZ_W   = $clog2(LD_BUS_SIZE*LD_DAT_CYC_NUM*LD_CHUNK_NUM+1);

endpackage

// File: rtl/sram_chunk_loader_if.sv
// Beat stream in and SRAM write port out of the chunk loader.
// master: the loader (stream sink, SRAM write transmitter); slave: its environment.
interface sram_chunk_loader_if #(
  parameter int BUS_SIZE    = 32,
  parameter int DAT_CYC_NUM = 4,
  parameter int CHUNK_NUM   = 8
);
  import loader_pkg::*;

  localparam int BW = cnt_w(DAT_CYC_NUM);
  localparam int CW = cnt_w(CHUNK_NUM);

  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [BUS_SIZE-1:0]   s_sparsemap_i;
  logic [BUS_SIZE*8-1:0] s_nonzero_data_i;

  logic                  sram_wr_valid_o;
  logic [BUS_SIZE-1:0]   sram_wr_sparsemap_o;
  logic [BUS_SIZE*8-1:0] sram_wr_nonzero_data_o;
  logic [BW-1:0]         sram_wr_dat_count_o;
  logic [CW-1:0]         sram_wr_chunk_count_o;

  modport master (
    input  s_valid_i, s_sparsemap_i, s_nonzero_data_i,
    output s_ready_o, sram_wr_valid_o, sram_wr_sparsemap_o,
           sram_wr_nonzero_data_o, sram_wr_dat_count_o, sram_wr_chunk_count_o
  );

  modport slave (
    output s_valid_i, s_sparsemap_i, s_nonzero_data_i,
    input  s_ready_o, sram_wr_valid_o, sram_wr_sparsemap_o,
           sram_wr_nonzero_data_o, sram_wr_dat_count_o, sram_wr_chunk_count_o
  );

endinterface

// File: rtl/sram_chunk_loader_popcount.sv
// Combinational population count of one beat's sparsemap.
module sparsemap_popcount #(
  parameter int BUS_SIZE = 32,
  parameter int CNT_W    = $clog2(BUS_SIZE+1)
) (
  input  logic [BUS_SIZE-1:0] sparsemap_i,
  output logic [CNT_W-1:0]    count_o
);

  // Plain adder chain; synthesis restructures it into a tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < BUS_SIZE; i++)
      count_o = count_o + CNT_W'(sparsemap_i[i]);
  end

endmodule

// File: rtl/sram_chunk_loader.sv
// Write-side sequencer for an IFM/filter chunk SRAM: takes a beat stream and
// emits registered SRAM writes tagged with beat and chunk indices.
// Optional LOADER_NNZ_COUNT_EN adds nnz_count_o, a running popcount of the
// sparsemaps accepted in the current transfer.
module sram_chunk_loader
  import loader_pkg::*;
#(
  parameter int BUS_SIZE    = LD_BUS_SIZE,
  parameter int DAT_CYC_NUM = LD_DAT_CYC_NUM,
  parameter int CHUNK_NUM   = LD_CHUNK_NUM,
  parameter int BW          = cnt_w(DAT_CYC_NUM),
  parameter int CW          = cnt_w(CHUNK_NUM),
  parameter int NW          = $clog2(BUS_SIZE*DAT_CYC_NUM*CHUNK_NUM+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CW-1:0]        chunk_base_i,
  input  logic [CW-1:0]        chunk_len_i,
  input  logic                 abort_i,
  sram_chunk_loader_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o
`ifdef LOADER_NNZ_COUNT_EN
  ,
  output logic [NW-1:0]        nnz_count_o
`endif
);

  loader_state_e state_q, state_d;

  logic [BW-1:0] beat_q;
  logic [CW-1:0] chunk_q;
  logic [CW:0]   rem_q;      // one extra bit so len=0 can hold CHUNK_NUM

  logic accept, beat_last, xfer_last, start_go;

  assign bus.s_ready_o = (state_q == LOAD);
  assign busy_o        = (state_q == LOAD);
  assign accept        = bus.s_valid_i & bus.s_ready_o;
  assign beat_last     = (beat_q == BW'(DAT_CYC_NUM-1));
  assign xfer_last     = accept & beat_last & (rem_q == (CW+1)'(1));
  assign start_go      = (state_q == IDLE) & start_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: completion and abort both return to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: if (xfer_last || abort_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat, chunk and remaining-chunk counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beat_q  <= '0;
      chunk_q <= '0;
      rem_q   <= '0;
    end else if (start_go) begin
      beat_q  <= '0;
      chunk_q <= chunk_base_i;
      rem_q   <= (chunk_len_i == '0) ? (CW+1)'(CHUNK_NUM) : {1'b0, chunk_len_i};
    end else if (accept) begin
      if (beat_last) begin
        beat_q  <= '0;
        chunk_q <= (chunk_q == CW'(CHUNK_NUM-1)) ? '0 : chunk_q + 1'b1;
        rem_q   <= rem_q - 1'b1;
      end else begin
        beat_q  <= beat_q + 1'b1;
      end
    end
  end

  // Registered write port; payload holds between strobes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.sram_wr_valid_o        <= 1'b0;
      bus.sram_wr_sparsemap_o    <= '0;
      bus.sram_wr_nonzero_data_o <= '0;
      bus.sram_wr_dat_count_o    <= '0;
      bus.sram_wr_chunk_count_o  <= '0;
      done_o                     <= 1'b0;
    end else begin
      bus.sram_wr_valid_o <= accept;
      done_o              <= xfer_last;
      if (accept) begin
        bus.sram_wr_sparsemap_o    <= bus.s_sparsemap_i;
        bus.sram_wr_nonzero_data_o <= bus.s_nonzero_data_i;
        bus.sram_wr_dat_count_o    <= beat_q;
        bus.sram_wr_chunk_count_o  <= chunk_q;
      end
    end
  end

`ifdef LOADER_NNZ_COUNT_EN
  localparam int PW = $clog2(BUS_SIZE+1);
  logic [PW-1:0] beat_pop;

  sparsemap_popcount #(.BUS_SIZE(BUS_SIZE), .CNT_W(PW)) u_pop (
    .sparsemap_i (bus.s_sparsemap_i),
    .count_o     (beat_pop)
  );

  // Nonzero accumulator, aligned with the write it belongs to.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        nnz_count_o <= '0;
    else if (start_go) nnz_count_o <= '0;
    else if (accept)   nnz_count_o <= nnz_count_o + NW'(beat_pop);
  end
`endif

endmodule

// File: tb/tb_sram_chunk_loader.sv
// Randomized self-checking bench for sram_chunk_loader against a queue-based
// model of the expected (chunk, beat) write sequence.
module tb_sram_chunk_loader;

  localparam int BUS  = 32;
  localparam int DATN = 4;
  localparam int CHN  = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i, abort_i, busy_o, done_o;
  logic [2:0] chunk_base_i, chunk_len_i;
`ifdef LOADER_NNZ_COUNT_EN
  logic [10:0] nnz_count_o;
`endif

  sram_chunk_loader_if #(.BUS_SIZE(BUS), .DAT_CYC_NUM(DATN), .CHUNK_NUM(CHN)) bus ();

  sram_chunk_loader #(.BUS_SIZE(BUS), .DAT_CYC_NUM(DATN), .CHUNK_NUM(CHN)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .chunk_base_i (chunk_base_i),
    .chunk_len_i  (chunk_len_i),
    .abort_i      (abort_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef LOADER_NNZ_COUNT_EN
    ,
    .nnz_count_o  (nnz_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model state: pending (chunk, beat) writes of the active transfer.
  int           q_chunk[$];
  int           q_beat[$];
  bit           m_load;
  bit           e_wv, e_done;
  logic [31:0]  e_sm;
  logic [255:0] e_d;
  int           e_dat, e_chunk, e_nnz;
  int           nwr, ndone, k;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, check outputs on the falling edge.
  task automatic step(input bit st, input int b, input int l, input bit ab,
                      input bit v, input logic [31:0] sm);
    logic [255:0] d;
    bit was_load;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start_i = st; chunk_base_i = 3'(b); chunk_len_i = 3'(l); abort_i = ab;
    bus.s_valid_i = v; bus.s_sparsemap_i = sm; bus.s_nonzero_data_i = d;

    was_load = m_load;
    e_wv = 1'b0; e_done = 1'b0;
    if (v && was_load) begin
      e_wv = 1'b1; e_sm = sm; e_d = d;
      e_chunk = q_chunk.pop_front(); e_dat = q_beat.pop_front();
      e_nnz += $countones(sm);
      if (q_chunk.size() == 0) begin e_done = 1'b1; m_load = 1'b0; end
    end
    if (was_load && m_load && ab) begin
      m_load = 1'b0; q_chunk.delete(); q_beat.delete();
    end else if (!was_load && st) begin
      int n;
      n = (l == 0) ? CHN : l;
      for (int c = 0; c < n; c++)
        for (int j = 0; j < DATN; j++) begin
          q_chunk.push_back((b + c) % CHN); q_beat.push_back(j);
        end
      m_load = 1'b1; e_nnz = 0;
    end

    @(posedge clk_i);
    @(negedge clk_i);
    chk("ready", bus.s_ready_o, m_load);
    chk("busy", busy_o, m_load);
    chk("wr_valid", bus.sram_wr_valid_o, e_wv);
    chk("done", done_o, e_done);
    chk("wr_smap", bus.sram_wr_sparsemap_o, e_sm);
    chk("wr_data", bus.sram_wr_nonzero_data_o, e_d);
    chk("dat_cnt", bus.sram_wr_dat_count_o, e_dat);
    chk("chunk_cnt", bus.sram_wr_chunk_count_o, e_chunk);
`ifdef LOADER_NNZ_COUNT_EN
    chk("nnz", nnz_count_o, e_nnz);
`endif
    if (bus.sram_wr_valid_o) nwr++;
    if (done_o) ndone++;
  endtask

  // Full transfer with valid gaps (percent), optional abort at beat index,
  // optional start_i noise held high during LOAD.
  task automatic xfer(input int b, input int l, input int abort_at,
                      input int gap, input bit noise);
    int guard;
    nwr = 0; ndone = 0; k = 0; guard = 0;
    step(1'b1, b, l, 1'b0, 1'b0, $urandom);
    while (m_load && guard < 400) begin
      bit v, ab;
      v  = ($urandom_range(99) >= gap);
      ab = v && (k == abort_at);
      step(noise, $urandom_range(7), $urandom_range(7), ab, v, $urandom);
      if (v) k++;
      guard++;
    end
    if (guard >= 400) chk("xfer_timeout", 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    m_load = 0; e_wv = 0; e_done = 0; e_sm = '0; e_d = '0; e_dat = 0; e_chunk = 0; e_nnz = 0;
    rst_i = 1'b0; start_i = 0; abort_i = 0; chunk_base_i = 0; chunk_len_i = 0;
    bus.s_valid_i = 0; bus.s_sparsemap_i = '0; bus.s_nonzero_data_i = '0;
    #12;
    chk("rst_ready", bus.s_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wv", bus.sram_wr_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Valid while idle must not be accepted; abort while idle is ignored.
    step(1'b0, 0, 0, 1'b1, 1'b1, $urandom);
    step(1'b0, 0, 0, 1'b0, 1'b1, $urandom);

    xfer(2, 1, -1, 0, 1'b0);
    chk("single_nwr", nwr, 4);
    chk("single_ndone", ndone, 1);

    xfer(6, 3, -1, 0, 1'b0);
    chk("wrap_nwr", nwr, 12);
    chk("wrap_ndone", ndone, 1);

    xfer(6, 0, -1, 0, 1'b0);
    chk("len0_nwr", nwr, 32);
    chk("len0_ndone", ndone, 1);

    xfer(1, 2, -1, 45, 1'b0);
    chk("bp_nwr", nwr, 8);

    xfer(0, 2, 5, 0, 1'b0);
    chk("abort_nwr", nwr, 6);
    chk("abort_ndone", ndone, 0);

    xfer(3, 1, 3, 0, 1'b0);
    chk("abort_fin_ndone", ndone, 1);

    xfer(5, 2, -1, 20, 1'b1);
    chk("ign_start_nwr", nwr, 8);

    // Reset asserted mid-transfer.
    step(1'b1, 4, 2, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b1, $urandom);
    #1 rst_i = 1'b0;
    #1;
    chk("mrst_ready", bus.s_ready_o, 1'b0);
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_wv", bus.sram_wr_valid_o, 1'b0);
    chk("mrst_smap", bus.sram_wr_sparsemap_o, 32'h0);
    chk("mrst_dat", bus.sram_wr_dat_count_o, 2'd0);
    chk("mrst_chunk", bus.sram_wr_chunk_count_o, 3'd0);
    m_load = 0; q_chunk.delete(); q_beat.delete();
    e_wv = 0; e_done = 0; e_sm = '0; e_d = '0; e_dat = 0; e_chunk = 0; e_nnz = 0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    step(1'b0, 0, 0, 1'b0, 1'b1, $urandom);
    xfer(7, 1, -1, 0, 1'b0);
    chk("post_rst_nwr", nwr, 4);

`ifdef LOADER_NNZ_COUNT_EN
    step(1'b1, 0, 1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 0, 0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 32'h1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 32'h8000_0001);
    chk("nnz_done", done_o, 1'b1);
    chk("nnz_35", nnz_count_o, 11'd35);
    step(1'b0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("nnz_hold", nnz_count_o, 11'd35);
`endif

    // Free-running random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(7) == 0, $urandom_range(7), $urandom_range(7),
           $urandom_range(39) == 0, $urandom_range(9) < 7, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
